seq_detect: RTL and testbench

SEQ_DETECT -- requirements
Module: seq_detect

---
 rtl/seq_detect.sv | 84 ++++++++
 tb/tb_seq_detect.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_detect.sv
// Serial pattern detector with a loadable PAT_W-bit pattern, optional overlapping detection
// and a saturating match counter.
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | no history bits collected (fcnt = 0)
// FILL  | partial history (0 < fcnt < PAT_W)
// ARMED | full window held, every bit can match
module seq_detect #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter logic [PAT_W-1:0] PAT_INIT = {PAT_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t           state;
  logic [PAT_W-1:0] pat;
  logic [PAT_W-1:0] hist;
  logic [FW-1:0]    fcnt;

  logic [PAT_W-1:0] hist_nx;
  logic [FW-1:0]    fcnt_nx;
  logic             accept;
  logic             match;

  always_comb begin
    hist_nx = {hist[PAT_W-2:0], in};
    fcnt_nx = (state == ARMED) ? fcnt : fcnt + 1'b1;
    accept  = en && !pat_load;
    match   = accept && (fcnt_nx == FULL) && (hist_nx == pat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pat   <= PAT_INIT;
      hist  <= '0;
      fcnt  <= '0;
      out   <= 1'b0;
      count <= '0;
    end else begin
      out <= 1'b0;
      if (pat_load) begin
        pat   <= pat_in;
        hist  <= '0;
        fcnt  <= '0;
        state <= IDLE;
      end else if (en) begin
        hist <= hist_nx;
        out  <= match;
        // Non-overlapping mode restarts the fill so the next match needs a fresh window
        if (match && !overlap) begin
          fcnt  <= '0;
          state <= IDLE;
        end else begin
          fcnt  <= fcnt_nx;
          state <= (fcnt_nx == FULL) ? ARMED : FILL;
        end
      end

      if (cnt_clr)
        count <= match ? CNT_W'(1) : '0;
      else if (match && count != CNT_MAX)
        count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect.sv
// Directed bench for seq_detect: a default instance (CNT_W=8) and a CNT_W=2 instance
// driven by the same stimulus for the saturation checks.
module tb_seq_detect;

  logic       clk = 1'b0;
  logic       rst, en, in_b, pat_load, overlap, cnt_clr;
  logic [3:0] pat_in;
  logic       out1, out2;
  logic [7:0] count1;
  logic [1:0] count2;
  int         n_vec = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  seq_detect #(.PAT_W(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .cnt_clr(cnt_clr), .out(out1), .count(count1)
  );

  seq_detect #(.PAT_W(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .en(en), .in(in_b), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .cnt_clr(cnt_clr), .out(out2), .count(count2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic b, input logic exp_out, input string tag);
    en = 1'b1; in_b = b; pat_load = 1'b0; cnt_clr = 1'b0;
    tick();
    en = 1'b0;
    check(tag, 32'(out1), 32'(exp_out));
  endtask

  task automatic load(input logic [3:0] p);
    pat_load = 1'b1; pat_in = p; en = 1'b1; in_b = 1'b1;
    tick();
    pat_load = 1'b0; en = 1'b0;
    check("load_out", 32'(out1), 32'd0);
  endtask

  task automatic gap();
    en = 1'b0;
    tick();
    check("gap_out", 32'(out1), 32'd0);
  endtask

  task automatic clear();
    cnt_clr = 1'b1; en = 1'b0;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    logic [6:0] s7;
    logic [6:0] e7;
    logic [3:0] s4;
    logic [3:0] e4;

    rst = 1'b1; en = 1'b0; in_b = 1'b0; pat_load = 1'b0; pat_in = 4'h0;
    overlap = 1'b1; cnt_clr = 1'b0;

    // Reset with random activity on the other inputs
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); in_b = 1'($urandom); pat_load = 1'($urandom);
      pat_in = 4'($urandom); cnt_clr = 1'($urandom);
      tick();
    end
    rst = 1'b0; en = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
    check("rst_out", 32'(out1), 32'd0);
    check("rst_count", 32'(count1), 32'd0);
    check("rst_count_sat", 32'(count2), 32'd0);

    // Default pattern 1111 straight after reset
    for (int i = 0; i < 4; i++) shift(1'b1, (i == 3), "init_1111");
    check("init_count", 32'(count1), 32'd1);

    // Overlapping detection of 1011
    clear();
    load(4'b1011);
    overlap = 1'b1;
    s7 = 7'b1011011; e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) shift(s7[i], e7[i], "ovl_out");
    check("ovl_count", 32'(count1), 32'd2);

    // Non-overlapping detection of the same stream, then a fresh window
    clear();
    load(4'b1011);
    overlap = 1'b0;
    s7 = 7'b1011011; e7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) shift(s7[i], e7[i], "novl_out");
    check("novl_count1", 32'(count1), 32'd1);
    s4 = 4'b1011; e4 = 4'b0001;
    for (int i = 3; i >= 0; i--) shift(s4[i], e4[i], "novl_append");
    check("novl_count2", 32'(count1), 32'd2);

    // Idle gaps inside a sequence
    load(4'b1011);
    overlap = 1'b1;
    shift(1'b1, 1'b0, "gap_b1");
    shift(1'b0, 1'b0, "gap_b2");
    for (int i = 0; i < 3; i++) gap();
    shift(1'b1, 1'b0, "gap_b3");
    shift(1'b1, 1'b1, "gap_b4");
    check("gap_count", 32'(count1), 32'd3);

    // pat_load mid-sequence discards history and its own in bit
    load(4'b1011);
    shift(1'b1, 1'b0, "midload_b1");
    shift(1'b0, 1'b0, "midload_b2");
    shift(1'b1, 1'b0, "midload_b3");
    load(4'b1011);
    check("load_keeps_count", 32'(count1), 32'd3);
    shift(1'b1, 1'b0, "midload_after");

    // Reset mid-sequence restores PAT_INIT and restarts the fill
    load(4'b0000);
    shift(1'b0, 1'b0, "midrst_b1");
    shift(1'b0, 1'b0, "midrst_b2");
    shift(1'b0, 1'b0, "midrst_b3");
    rst = 1'b1; en = 1'b1; in_b = 1'b0; cnt_clr = 1'b0;
    tick();
    rst = 1'b0; en = 1'b0;
    check("midrst_count", 32'(count1), 32'd0);
    for (int i = 0; i < 4; i++) shift(1'b1, (i == 3), "midrst_1111");

    // Saturation on the CNT_W=2 instance, then clear with and without a match
    clear();
    overlap = 1'b1;
    load(4'b1111);
    for (int i = 0; i < 8; i++) shift(1'b1, (i >= 3), "sat_out");
    check("sat_count8", 32'(count1), 32'd5);
    check("sat_count2", 32'(count2), 32'd3);
    cnt_clr = 1'b1; en = 1'b1; in_b = 1'b1;
    tick();
    cnt_clr = 1'b0; en = 1'b0;
    check("clr_match_out", 32'(out2), 32'd1);
    check("clr_match_count2", 32'(count2), 32'd1);
    check("clr_match_count8", 32'(count1), 32'd1);
    clear();
    check("clr_only_count2", 32'(count2), 32'd0);
    check("clr_only_count8", 32'(count1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
